// File: rtl/dot_accum.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dot_accum : fp16 partial-sum accumulator behind a 128-input adder tree,    |
// |             with shadow valid pipeline, credit back-pressure, result FIFO. |
// | Optional macro DOT_ACCUM_RELU_EN clamps negative results on push.         |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module dot_accum #(
  parameter int TREE_LAT = 7,
  parameter int DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  input  logic [15:0] tree_sum,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(TREE_LAT + 1);
  localparam int SW = ((CW > PW) ? CW : PW) + 1;

  // IEEE fp16 add, round-to-nearest-even, with three guard/round/sticky bits.
  function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x, y;
    logic [10:0] mx, my;
    logic [5:0]  ex, ey, e, d;
    logic [13:0] ax, sy, lost;
    logic [14:0] s;
    logic [11:0] m;
    logic        inc;
    begin
      if ((a[14:10] == 5'h1f && a[9:0] != 10'h0) || (b[14:10] == 5'h1f && b[9:0] != 10'h0))
        return 16'h7E00;
      if (a[14:10] == 5'h1f)
        return (b[14:10] == 5'h1f && a[15] != b[15]) ? 16'h7E00 : a;
      if (b[14:10] == 5'h1f)
        return b;
      if (a[14:0] >= b[14:0]) begin x = a; y = b; end
      else                    begin x = b; y = a; end
      ex   = (x[14:10] == 5'h0) ? 6'd1 : {1'b0, x[14:10]};
      ey   = (y[14:10] == 5'h0) ? 6'd1 : {1'b0, y[14:10]};
      mx   = {x[14:10] != 5'h0, x[9:0]};
      my   = {y[14:10] != 5'h0, y[9:0]};
      d    = ex - ey;
      ax   = {mx, 3'b000};
      lost = '0;
      if (d >= 6'd14) begin
        sy = {13'h0, |my};
      end else begin
        sy    = {my, 3'b000} >> d;
        lost  = {my, 3'b000} & ((14'h1 << d) - 14'h1);
        sy[0] = sy[0] | (|lost);
      end
      s = (x[15] == y[15]) ? ({1'b0, ax} + {1'b0, sy}) : ({1'b0, ax} - {1'b0, sy});
      if (s == 15'h0)
        return {x[15] & y[15], 15'h0};
      e = ex;
      if (s[14]) begin
        s = {1'b0, s[14:2], s[1] | s[0]};
        e = e + 6'd1;
      end
      for (int i = 0; i < 13; i++) begin
        if (!s[13] && e > 6'd1) begin
          s = s << 1;
          e = e - 6'd1;
        end
      end
      inc = s[2] & (s[1] | s[0] | s[3]);
      m   = {1'b0, s[13:3]} + {11'h0, inc};
      if (m[11]) begin
        m = m >> 1;
        e = e + 6'd1;
      end
      if (e >= 6'd31)
        return {x[15], 5'h1f, 10'h0};
      return {x[15], m[10] ? e[4:0] : 5'h0, m[9:0]};
    end
  endfunction

  logic [TREE_LAT-1:0] r_sv, r_sl;
  logic [15:0]         r_acc;
  logic                r_first;
  logic [15:0]         r_mem [DEPTH];
  logic [AW-1:0]       r_wr, r_rd;
  logic [CW-1:0]       r_count;

  logic          w_issue, w_vd, w_ld, w_push, w_pop;
  logic [15:0]   w_sum, w_push_val;
  logic [PW-1:0] w_pending;

  assign w_issue = in_valid & in_ready;
  assign w_vd    = r_sv[TREE_LAT-1];
  assign w_ld    = r_sl[TREE_LAT-1];
  assign w_sum   = r_first ? tree_sum : fp16_add(r_acc, tree_sum);
  assign w_push  = w_vd & w_ld;
  assign w_pop   = out_valid & out_ready;

`ifdef DOT_ACCUM_RELU_EN
  assign w_push_val = w_sum[15] ? 16'h0000 : w_sum;
`else
  assign w_push_val = w_sum;
`endif

  always_comb begin
    w_pending = '0;
    for (int i = 0; i < TREE_LAT; i++)
      w_pending = w_pending + PW'(r_sl[i]);
  end

  // Last chunks still in the tree hold a FIFO slot in reserve.
  assign in_ready  = (SW'(r_count) + SW'(w_pending)) < SW'(DEPTH);
  assign out_valid = (r_count != '0);
  assign out_data  = r_mem[r_rd];
  assign busy      = (|r_sv) | ~r_first;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sv    <= '0;
      r_sl    <= '0;
      r_acc   <= 16'h0000;
      r_first <= 1'b1;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= 16'h0000;
    end else begin
      r_sv <= {r_sv[TREE_LAT-2:0], w_issue};
      r_sl <= {r_sl[TREE_LAT-2:0], w_issue & in_last};
      if (w_vd) begin
        r_acc   <= w_sum;
        r_first <= w_ld;
      end
      if (w_push) begin
        r_mem[r_wr] <= w_push_val;
        r_wr        <= r_wr + AW'(1);
      end
      if (w_pop)
        r_rd <= r_rd + AW'(1);
      if (w_push && !w_pop)
        r_count <= r_count + CW'(1);
      else if (!w_push && w_pop)
        r_count <= r_count - CW'(1);
    end
  end
endmodule
`default_nettype wire
